parity_sched: RTL and testbench

- Shares one bit-serial `parity` FSM among NREQ requesters.
- Each requester presents a parallel WIDTH-bit word. The scheduler grants one requester round-robin and clears the parity unit.
- It then shifts the word in LSB-first, one bit per clock, samples the parity result and returns it with the requester id over a ready/valid response port.
- It sits between word-level producers and the existing serial parity engine.

---
 rtl/parity_sched.sv | 156 +++++++++++++++
 tb/tb_parity_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_sched.sv
// parity_sched: round-robin front end that feeds one requester's word at a
// time, LSB first, into a shared bit-serial parity unit and returns the
// sampled parity with the requester id over a ready/valid port.
module parity_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  par_rst,
    output logic                  par_bit,
    input  logic                  par_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_parity,
    output logic [IDW-1:0]        resp_id
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        SAMPLE,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_par_rst;
    logic              r_par_bit;
    logic              r_resp_valid;
    logic              r_resp_parity;
    logic [IDW-1:0]    r_resp_id;
    logic [IDW-1:0]    r_last;
    logic [IDW-1:0]    r_id;
    logic [WIDTH-1:0]  r_word;
    logic [CW-1:0]     r_cnt;

    logic              w_found;
    logic [IDW-1:0]    w_pick;
    logic [WIDTH-1:0]  w_word;

    // Round-robin search starting one past the last granted requester.
    always_comb begin : arb
        int unsigned k;
        k       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        w_word  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k = (32'(r_last) + i) % NREQ;
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_pick  = IDW'(k);
                w_word  = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = CLEAR;
            CLEAR:   w_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(WIDTH)) w_next = SAMPLE;
            SAMPLE:  w_next = RESP;
            RESP:    if (r_resp_valid && resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Registered outputs and datapath. Outputs lag the state by one cycle,
    // so SHIFT spends one extra cycle (counter == WIDTH) letting the parity
    // unit absorb the last bit before SAMPLE latches it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt         <= '0;
            r_busy        <= 1'b0;
            r_par_rst     <= 1'b1;
            r_par_bit     <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_parity <= 1'b0;
            r_resp_id     <= '0;
            r_last        <= IDW'(NREQ - 1);
            r_id          <= '0;
            r_word        <= '0;
            r_cnt         <= '0;
        end else begin
            r_gnt  <= '0;
            r_busy <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    r_par_rst <= 1'b0;
                    r_par_bit <= 1'b0;
                    if (w_found) begin
                        r_gnt  <= NREQ'(1) << w_pick;
                        r_word <= w_word;
                        r_id   <= w_pick;
                        r_last <= w_pick;
                    end
                end
                CLEAR: begin
                    r_par_rst <= 1'b1;
                    r_par_bit <= 1'b0;
                    r_cnt     <= '0;
                end
                SHIFT: begin
                    r_par_rst <= 1'b0;
                    if (r_cnt == CW'(WIDTH)) begin
                        r_par_bit <= 1'b0;
                    end else begin
                        r_par_bit <= r_word[0];
                        r_word    <= r_word >> 1;
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    r_par_bit     <= 1'b0;
                    r_resp_parity <= par_out;
                    r_resp_valid  <= 1'b1;
                    r_resp_id     <= r_id;
                end
                RESP: begin
                    if (r_resp_valid && resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign par_rst     = r_par_rst;
    assign par_bit     = r_par_bit;
    assign resp_valid  = r_resp_valid;
    assign resp_parity = r_resp_parity;
    assign resp_id     = r_resp_id;

endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: directed bench with a response scoreboard and a
// behavioural model of the serial parity unit.
module tb_parity_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  par_rst;
    logic                  par_bit;
    logic                  par_out;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_parity;
    logic [IDW-1:0]        resp_id;

    typedef struct {
        logic [IDW-1:0] id;
        logic           par;
    } exp_t;

    exp_t sbq[$];
    int   n_checks;
    int   n_fail;

    parity_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .busy(busy), .par_rst(par_rst), .par_bit(par_bit),
        .par_out(par_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_parity(resp_parity), .resp_id(resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial parity unit model.
    always @(posedge clk) begin
        if (par_rst) par_out <= 1'b0;
        else         par_out <= par_out ^ par_bit;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every accepted response.
    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d parity %0d expected none", resp_id, resp_parity);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_parity", 32'(resp_parity), 32'(e.par));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [WIDTH-1:0] w);
        req_data[idx*WIDTH +: WIDTH] = w;
    endtask

    // Wait (bounded) for a grant, check it and queue the expected response.
    task automatic expect_grant(input logic [NREQ-1:0] exp_gnt, input int exp_id, input logic exp_par);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt != '0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got none expected %b", exp_gnt);
        end else begin
            chk("gnt", 32'(gnt), 32'(exp_gnt));
            sbq.push_back('{id: IDW'(exp_id), par: exp_par});
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!busy && !resp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy %0d expected 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] wb5;
        logic [7:0] w3[4];
        logic       p3[4];
        n_checks = 0;
        n_fail   = 0;
        wb5      = 8'hB5;
        w3       = '{8'h3C, 8'h00, 8'hFF, 8'h01};
        p3       = '{1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with all requests asserted.
        reset      = 1'b0;
        req        = 4'b1111;
        resp_ready = 1'b1;
        set_word(0, 8'hB5);
        set_word(1, 8'h3C);
        set_word(2, 8'h3C);
        set_word(3, 8'h5B);
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_par_rst", 32'(par_rst), 32'h1);
        reset = 1'b1;
        expect_grant(4'b0001, 0, 1'b1);
        req = '0;
        wait_idle();

        // Single request, detailed timing of B5.
        req = 4'b0001;
        expect_grant(4'b0001, 0, 1'b1);
        req = '0;
        tick();
        chk("clear_par_rst", 32'(par_rst), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("shift_par_bit", 32'(par_bit), 32'(wb5[k]));
            chk("shift_par_rst", 32'(par_rst), 32'h0);
        end
        tick();
        chk("t10_resp_valid", 32'(resp_valid), 32'h0);
        tick();
        chk("t11_resp_valid", 32'(resp_valid), 32'h1);
        chk("t11_resp_id", 32'(resp_id), 32'h0);
        chk("t11_resp_parity", 32'(resp_parity), 32'h1);
        wait_idle();

        // Even/odd words on requester 2.
        for (int n = 0; n < 4; n++) begin
            set_word(2, w3[n]);
            req = 4'b0100;
            expect_grant(4'b0100, 2, p3[n]);
            req = '0;
            wait_idle();
        end

        // Round-robin: park pointer on 3, then hold all requests.
        set_word(0, 8'hB5);
        set_word(1, 8'h3C);
        set_word(2, 8'h07);
        set_word(3, 8'hC3);
        req = 4'b1000;
        expect_grant(4'b1000, 3, 1'b0);
        req = 4'b1111;
        expect_grant(4'b0001, 0, 1'b1);
        expect_grant(4'b0010, 1, 1'b0);
        expect_grant(4'b0100, 2, 1'b1);
        expect_grant(4'b1000, 3, 1'b0);
        expect_grant(4'b0001, 0, 1'b1);
        expect_grant(4'b0010, 1, 1'b0);
        req = 4'b1010;
        expect_grant(4'b1000, 3, 1'b0);
        expect_grant(4'b0010, 1, 1'b0);
        req = '0;
        wait_idle();

        // Backpressure with 0 and 1 pending; pointer is at 1, so 0 goes first.
        resp_ready = 1'b0;
        req = 4'b0011;
        expect_grant(4'b0001, 0, 1'b1);
        begin
            bit up;
            up = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (resp_valid) begin
                    up = 1;
                    break;
                end
            end
            chk("bp_valid_seen", 32'(up), 32'h1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_id", 32'(resp_id), 32'h0);
            chk("bp_parity", 32'(resp_parity), 32'h1);
            chk("bp_gnt", 32'(gnt), 32'h0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_valid_drop", 32'(resp_valid), 32'h0);
        chk("bp_gnt_wait", 32'(gnt), 32'h0);
        tick();
        chk("bp_next_gnt", 32'(gnt), 32'b0010);
        sbq.push_back('{id: IDW'(1), par: 1'b0});
        req = '0;
        wait_idle();

        // Reset in the middle of SHIFT abandons the transaction.
        req = 4'b0001;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (gnt != '0) begin
                    seen = 1;
                    break;
                end
            end
            chk("mid_gnt", 32'(gnt), 32'b0001);
        end
        req = '0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_par_rst", 32'(par_rst), 32'h1);
        chk("mid_resp_valid", 32'(resp_valid), 32'h0);
        set_word(3, 8'h5B);
        req   = 4'b1000;
        reset = 1'b1;
        expect_grant(4'b1000, 3, 1'b1);
        req = '0;
        wait_idle();
        tick();

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
